ysyx_22050019_axi_rd_slave: RTL and testbench

AXI4 read-channel responder serving 64-bit instruction/data fetches from the core's AXI read masters (IFU, LSU). It accepts one AR request at a time, supports INCR bursts, reads a synchronous single-port memory with a programmable extra wait, and returns beats on R with full backpressure. It sits between the interconnect and the simulation/FPGA main memory model.

---
 rtl/ysyx_22050019_axi_pkg.sv | 16 +
 rtl/ysyx_22050019_axi_rd_slave.sv | 122 ++++++++++++
 tb/tb_ysyx_22050019_axi_rd_slave.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared AXI response codes and responder state encodings.
// Used by the read responder and the future write responder.
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT,
    RESP
  } rd_state_t;

endpackage

// File: rtl/ysyx_22050019_axi_rd_slave.sv
// AXI4 read responder: one AR at a time, INCR bursts of 8-byte beats,
// synchronous external memory with a programmable pre-read wait.
module ysyx_22050019_axi_rd_slave
  import ysyx_22050019_axi_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE  = 64'h0800_0000,
  parameter int          WAIT_CYC  = 0,
  parameter int          ID_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  input  logic [63:0]     s_axi_araddr,
  input  logic [7:0]      s_axi_arlen,
  input  logic [ID_W-1:0] s_axi_arid,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  output logic [63:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic [ID_W-1:0] s_axi_rid,
  output logic            mem_ren,
  output logic [63:0]     mem_raddr,
  input  logic [63:0]     mem_rdata
);

  localparam logic [3:0] WAIT_N = 4'(WAIT_CYC);

  rd_state_t       state_q, state_d;
  logic [63:0]     addr_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_q;
  logic [3:0]      cnt_q;
  logic [ID_W-1:0] id_q;
  logic [63:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic            in_range;
  logic            last;

  // Unsigned wrap makes addresses below the base fail the compare too.
  assign in_range = (addr_q - BASE_ADDR) < MEM_SIZE;
  assign last     = beat_q == len_q;

  always_comb begin
    state_d = state_q;
    mem_ren = 1'b0;
    unique case (state_q)
      IDLE: if (s_axi_arvalid) state_d = WAIT;
      WAIT: begin
        if (!in_range) begin
          state_d = RESP;
        end else if (cnt_q == '0) begin
          mem_ren = 1'b1;
          state_d = CAPT;
        end
      end
      CAPT: state_d = RESP;
      RESP: if (s_axi_rready) state_d = last ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_axi_arvalid) begin
            addr_q <= s_axi_araddr & ~64'h7;
            len_q  <= s_axi_arlen;
            id_q   <= s_axi_arid;
            beat_q <= '0;
            cnt_q  <= WAIT_N;
          end
        end
        WAIT: begin
          if (!in_range) begin
            rdata_q <= '0;
            rresp_q <= RESP_DECERR;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        CAPT: begin
          rdata_q <= mem_rdata;
          rresp_q <= RESP_OKAY;
        end
        RESP: begin
          if (s_axi_rready && !last) begin
            addr_q <= addr_q + 64'd8;
            beat_q <= beat_q + 8'd1;
            cnt_q  <= WAIT_N;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi_arready = state_q == IDLE;
  assign s_axi_rvalid  = state_q == RESP;
  assign s_axi_rlast   = (state_q == RESP) && last;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = id_q;
  assign mem_raddr     = addr_q;

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_slave.sv
// Bench for the AXI read responder: two instances (wait 0 and 4)
// share stimulus; a transaction-level model predicts every cycle.
`timescale 1ns/1ps
module tb_ysyx_22050019_axi_rd_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;
  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic arvalid = 1'b0;
  logic [63:0] araddr = '0;
  logic [7:0] arlen = '0;
  logic [ID_W-1:0] arid = '0;
  logic rready = 1'b0;
  int tag = 0;
  int rr_mode = 0;

  logic [1:0] arready, rvalid, rlast, mem_ren;
  logic [1:0][63:0] rdata, mem_raddr, mem_rdata;
  logic [1:0][1:0] rresp;
  logic [1:0][ID_W-1:0] rid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] memf(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen
    ysyx_22050019_axi_rd_slave #(
      .BASE_ADDR(BASE),
      .MEM_SIZE (SIZE),
      .WAIT_CYC (g * 4),
      .ID_W     (ID_W)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axi_arvalid(arvalid),
      .s_axi_arready(arready[g]),
      .s_axi_araddr (araddr),
      .s_axi_arlen  (arlen),
      .s_axi_arid   (arid),
      .s_axi_rvalid (rvalid[g]),
      .s_axi_rready (rready),
      .s_axi_rdata  (rdata[g]),
      .s_axi_rresp  (rresp[g]),
      .s_axi_rlast  (rlast[g]),
      .s_axi_rid    (rid[g]),
      .mem_ren      (mem_ren[g]),
      .mem_raddr    (mem_raddr[g]),
      .mem_rdata    (mem_rdata[g])
    );
  end

  // Synchronous memory: data appears the cycle after the strobe.
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (mem_ren[g]) mem_rdata[g] <= memf(mem_raddr[g]);

  typedef struct {
    logic [63:0] addr;
    logic        inr;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  typedef enum int { P_IDLE, P_PEND, P_PRES } ph_t;

  beat_t exb [2][256];
  ph_t ph [2] = '{P_IDLE, P_IDLE};
  int k [2], cur [2], ttag [2], nb [2], nren [2];
  int lats [2][16];
  logic [63:0] rena [2][16];
  logic [63:0] dat [2][16];
  logic [1:0] rsp [2][16];

  task automatic chk(input string nm, input int g,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d act=%0h exp=%0h", nm, g, act, exp);
    end
  endtask

  // Hand-computed expectations pinning the model for directed bursts.
  task automatic lit(input int g);
    case (ttag[g])
      1: begin
        chk("t1_beats", g, 64'(nb[g]), 64'd1);
        chk("t1_data", g, dat[g][0], 64'h1122_3344_5566_7788);
        chk("t1_raddr", g, rena[g][0], 64'h8000_0000);
        chk("t1_lat", g, 64'(lats[g][0]), (g == 0) ? 64'd2 : 64'd6);
      end
      2: begin
        chk("t2_beats", g, 64'(nb[g]), 64'd4);
        chk("t2_ra0", g, rena[g][0], 64'h8000_0100);
        chk("t2_ra1", g, rena[g][1], 64'h8000_0108);
        chk("t2_ra2", g, rena[g][2], 64'h8000_0110);
        chk("t2_ra3", g, rena[g][3], 64'h8000_0118);
        chk("t2_lat3", g, 64'(lats[g][3]), (g == 0) ? 64'd2 : 64'd6);
      end
      3: begin
        chk("t3_beats", g, 64'(nb[g]), 64'd2);
        chk("t3_nren", g, 64'(nren[g]), 64'd2);
      end
      4: begin
        chk("t4_nren", g, 64'(nren[g]), 64'd0);
        chk("t4_resp0", g, 64'(rsp[g][0]), 64'd3);
        chk("t4_resp1", g, 64'(rsp[g][1]), 64'd3);
        chk("t4_data1", g, dat[g][1], 64'd0);
      end
      5: begin
        chk("t5_resp0", g, 64'(rsp[g][0]), 64'd0);
        chk("t5_resp1", g, 64'(rsp[g][1]), 64'd3);
        chk("t5_nren", g, 64'(nren[g]), 64'd1);
        chk("t5_raddr", g, rena[g][0], 64'h87FF_FFF8);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    beat_t b;
    int lat;
    int w;
    logic [63:0] a;
    for (int g = 0; g < 2; g++) begin
      w = g * 4;
      if (!rst_n) begin
        chk("rst_rvalid", g, 64'(rvalid[g]), 64'd0);
        chk("rst_arready", g, 64'(arready[g]), 64'd1);
        chk("rst_rlast", g, 64'(rlast[g]), 64'd0);
        chk("rst_rresp", g, 64'(rresp[g]), 64'd0);
        chk("rst_rdata", g, rdata[g], 64'd0);
        chk("rst_rid", g, 64'(rid[g]), 64'd0);
        chk("rst_ren", g, 64'(mem_ren[g]), 64'd0);
        ph[g] = P_IDLE;
      end else begin
        b = exb[g][cur[g]];
        lat = b.inr ? w + 2 : 1;
        if (ph[g] == P_PEND) begin
          if (rvalid[g] && nb[g] < 16) lats[g][nb[g]] = k[g];
          if (k[g] == lat) ph[g] = P_PRES;
        end
        chk("arready", g, 64'(arready[g]), 64'(ph[g] == P_IDLE));
        chk("rvalid", g, 64'(rvalid[g]), 64'(ph[g] == P_PRES));
        chk("mem_ren", g, 64'(mem_ren[g]),
            64'(ph[g] == P_PEND && b.inr && k[g] == w));
        if (mem_ren[g] && nren[g] < 16) rena[g][nren[g]] = mem_raddr[g];
        if (mem_ren[g]) nren[g]++;
        if (ph[g] == P_PEND && b.inr && k[g] == w)
          chk("mem_raddr", g, mem_raddr[g], b.addr);
        if (ph[g] == P_PRES) begin
          chk("rdata", g, rdata[g], b.data);
          chk("rresp", g, 64'(rresp[g]), 64'(b.resp));
          chk("rlast", g, 64'(rlast[g]), 64'(b.last));
          chk("rid", g, 64'(rid[g]), 64'(b.id));
        end
        case (ph[g])
          P_IDLE: begin
            if (arvalid) begin
              for (int i = 0; i <= int'(arlen); i++) begin
                a = (araddr & ~64'h7) + 64'(i) * 64'd8;
                exb[g][i].addr = a;
                exb[g][i].inr  = (a >= BASE) && (a < BASE + SIZE);
                exb[g][i].data = exb[g][i].inr ? memf(a) : 64'd0;
                exb[g][i].resp = exb[g][i].inr ? 2'b00 : 2'b11;
                exb[g][i].last = (i == int'(arlen));
                exb[g][i].id   = arid;
              end
              cur[g] = 0; k[g] = 0; nb[g] = 0; nren[g] = 0;
              ttag[g] = tag;
              ph[g] = P_PEND;
            end
          end
          P_PEND: k[g]++;
          default: begin
            if (rready) begin
              if (nb[g] < 16) begin
                dat[g][nb[g]] = rdata[g];
                rsp[g][nb[g]] = rresp[g];
              end
              nb[g]++;
              if (b.last) begin
                lit(g);
                ph[g] = P_IDLE;
              end else begin
                cur[g]++;
                k[g] = 0;
                ph[g] = P_PEND;
              end
            end
          end
        endcase
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0: rready = 1'b1;
      1: rready = 1'($urandom_range(0, 1));
      default: rready = 1'b0;
    endcase
  end

  task automatic issue(input logic [63:0] a, input logic [7:0] l,
                       input logic [3:0] id, input int t);
    @(posedge clk);
    #1;
    araddr = a; arlen = l; arid = id; tag = t; arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(arready == 2'b11 && rvalid == 2'b00)) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 3000) begin
        $display("FAIL idle_timeout act=busy exp=idle");
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic wait_rv0();
    int n = 0;
    while (!rvalid[0]) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        $display("FAIL rvalid_timeout act=0 exp=1");
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [7:0] l,
                      input logic [3:0] id, input int t);
    issue(a, l, id, t);
    wait_idle();
  endtask

  initial begin
    logic [63:0] a;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    rr_mode = 0;

    send(64'h8000_0004, 8'd0, 4'd3, 1);
    send(64'h8000_0100, 8'd3, 4'd5, 2);

    rr_mode = 2;
    issue(64'h8000_0200, 8'd1, 4'd7, 3);
    wait_rv0();
    repeat (5) @(posedge clk);
    #1 rr_mode = 0;
    wait_idle();

    send(64'h0000_1000, 8'd1, 4'd2, 4);
    send(BASE + SIZE - 64'd8, 8'd1, 4'd9, 5);

    rr_mode = 2;
    issue(64'h8000_0300, 8'd3, 4'd4, 0);
    wait_rv0();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rr_mode = 0;
    send(64'h8000_0004, 8'd0, 4'd3, 1);

    for (int t = 0; t < 40; t++) begin
      rr_mode = int'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: a = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
        1: a = BASE + SIZE - 64'd8 * 64'($urandom_range(1, 6))
               + 64'($urandom_range(0, 7));
        2: a = BASE - 64'd8 * 64'($urandom_range(0, 4));
        3: a = 64'hFFFF_FFFF_FFFF_FFF0;
        default: a = {$urandom, $urandom};
      endcase
      send(a, 8'($urandom_range(0, 7)), 4'($urandom), 0);
    end

    rr_mode = 0;
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
